apb_timer: RTL and testbench

Memory-mapped 32-bit timer/compare peripheral sitting downstream of the CPU's LSU APB master port. Decodes APB transfers with one fixed wait state, holds control/prescaler/count/compare/status registers, and raises a level interrupt when the free-running count matches the compare value. Placed on the APB bus beside other peripherals; the bus decoder drives its `PSEL`.

---
 rtl/apb_timer.sv | 198 +++++++++++++++++++
 tb/tb_apb_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_timer
// Purpose  : APB slave timer/compare peripheral. A prescaled 32-bit
//            free-running counter raises a level interrupt when it matches
//            a compare value. Every transfer has one fixed wait state.
// Ports    : clk      - system clock, all state on the rising edge
//            rst_n    - synchronous active-low reset
//            PSEL     - slave select from the bus decoder
//            PENABLE  - APB access phase
//            PWRITE   - 1 = write, 0 = read
//            PADDR    - byte address, only [4:0] decoded
//            PWDATA   - write data
//            PREADY   - transfer complete (registered)
//            PRDATA   - read data (registered), valid with PREADY
//            PSLVERR  - error response, valid with PREADY
//            irq      - level interrupt, STATUS.MATCH & CTRL.IRQ_EN
// Map      : 0x00 CTRL {IRQ_EN, AUTO_RELOAD, EN}, 0x04 PRESC, 0x08 COUNT,
//            0x0C CMP, 0x10 STATUS {MATCH} (write-1-to-clear)
// Revision : 1.0 - initial release
// ============================================================================
module apb_timer #(
  parameter int PADDR_W = 12,
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PSEL,
  input  logic               PENABLE,
  input  logic               PWRITE,
  input  logic [PADDR_W-1:0] PADDR,
  input  logic [31:0]        PWDATA,
  output logic               PREADY,
  output logic [31:0]        PRDATA,
  output logic               PSLVERR,
  output logic               irq
);

  localparam logic [4:0] c_OFF_CTRL   = 5'h00;
  localparam logic [4:0] c_OFF_PRESC  = 5'h04;
  localparam logic [4:0] c_OFF_COUNT  = 5'h08;
  localparam logic [4:0] c_OFF_CMP    = 5'h0C;
  localparam logic [4:0] c_OFF_STATUS = 5'h10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Bus-side output registers
  logic               r_pready;
  logic [31:0]        r_prdata;
  logic               r_pslverr;

  // Timer state
  logic [2:0]         r_ctrl;      // {IRQ_EN, AUTO_RELOAD, EN}
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [31:0]        r_count;
  logic [31:0]        r_cmp;
  logic               r_match;

  // Decode
  logic [4:0]         w_off;
  logic               w_addr_err;
  logic               w_commit;
  logic               w_wr_ctrl;
  logic               w_wr_presc;
  logic               w_wr_count;
  logic               w_wr_cmp;
  logic               w_wr_status;
  logic [31:0]        w_rdata;
  logic               w_tick;
  logic               w_hit;
  logic               w_unused;

  assign w_off      = PADDR[4:0];
  assign w_addr_err = (w_off[1:0] != 2'b00) || (w_off > c_OFF_STATUS);
  assign w_unused   = ^PADDR[PADDR_W-1:5];

  // ---------------------------------------------------------------------------
  // APB handshake FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (PSEL && !PENABLE) w_state_nxt = ST_WAIT;
      // A master that drops PSEL during the wait state abandons the transfer.
      ST_WAIT:  w_state_nxt = PSEL ? ST_READY : ST_IDLE;
      ST_READY: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Writes commit on the edge that ends the READY cycle.
  assign w_commit    = (r_state == ST_READY) && PSEL && PENABLE && r_pready
                       && PWRITE && !w_addr_err;
  assign w_wr_ctrl   = w_commit && (w_off == c_OFF_CTRL);
  assign w_wr_presc  = w_commit && (w_off == c_OFF_PRESC);
  assign w_wr_count  = w_commit && (w_off == c_OFF_COUNT);
  assign w_wr_cmp    = w_commit && (w_off == c_OFF_CMP);
  assign w_wr_status = w_commit && (w_off == c_OFF_STATUS);

  always_comb begin
    w_rdata = 32'h0;
    if (!w_addr_err) begin
      case (w_off)
        c_OFF_CTRL:   w_rdata = {29'h0, r_ctrl};
        c_OFF_PRESC:  w_rdata = {{(32-PRESC_W){1'b0}}, r_presc};
        c_OFF_COUNT:  w_rdata = r_count;
        c_OFF_CMP:    w_rdata = r_cmp;
        c_OFF_STATUS: w_rdata = {31'h0, r_match};
        default:      w_rdata = 32'h0;
      endcase
    end
  end

  // Response is captured at the end of the wait state so that read data
  // reflects register contents as of the access cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pready  <= 1'b0;
      r_prdata  <= 32'h0;
      r_pslverr <= 1'b0;
    end else if ((r_state == ST_WAIT) && PSEL) begin
      r_pready  <= 1'b1;
      r_prdata  <= w_rdata;
      r_pslverr <= w_addr_err;
    end else begin
      r_pready  <= 1'b0;
      r_prdata  <= 32'h0;
      r_pslverr <= 1'b0;
    end
  end

  assign PREADY  = r_pready;
  assign PRDATA  = r_prdata;
  assign PSLVERR = r_pslverr;

  // ---------------------------------------------------------------------------
  // Prescaler and counter
  // ---------------------------------------------------------------------------
  assign w_tick = r_ctrl[0] && (r_presc_cnt == r_presc);
  // A software write to COUNT overrides the tick, including its match.
  assign w_hit  = w_tick && !w_wr_count && (r_count == r_cmp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl      <= 3'b000;
      r_presc     <= '0;
      r_presc_cnt <= '0;
      r_count     <= 32'h0;
      r_cmp       <= 32'h0;
      r_match     <= 1'b0;
    end else begin
      if (w_wr_ctrl)  r_ctrl  <= PWDATA[2:0];
      if (w_wr_presc) r_presc <= PWDATA[PRESC_W-1:0];
      if (w_wr_cmp)   r_cmp   <= PWDATA;

      // Restart the prescale phase whenever the timebase or count is reloaded.
      if (!r_ctrl[0] || w_wr_presc || w_wr_count || w_tick) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + 1'b1;
      end

      if (w_wr_count) begin
        r_count <= PWDATA;
      end else if (w_tick) begin
        if (w_hit && r_ctrl[1]) r_count <= 32'h0;
        else                    r_count <= r_count + 32'h1;
      end

      // A new match wins over a simultaneous write-1-to-clear.
      if (w_hit) begin
        r_match <= 1'b1;
      end else if (w_wr_status && PWDATA[0]) begin
        r_match <= 1'b0;
      end
    end
  end

  assign irq = r_match & r_ctrl[2];

endmodule
`default_nettype wire

// File: tb/tb_apb_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_timer
// Purpose  : Directed self-checking bench for apb_timer: reset, handshake,
//            address errors, prescale/match, wrap, write collisions,
//            enable toggling and reset in the middle of a transfer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [11:0] PADDR = 12'h0;
  logic [31:0] PWDATA = 32'h0;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd;
  logic        er;
  logic        r1;
  logic        r2;

  always #5 clk = ~clk;

  apb_timer #(.PADDR_W(12), .PRESC_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One complete transfer: setup, access (wait), ready; returns 1ns after the
  // edge that ends the READY cycle.
  task automatic apb_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output logic rdy_t1, output logic rdy_t2);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    rdy_t1 = PREADY;
    @(posedge clk); #1;
    rdy_t2 = PREADY;
    rdata  = PRDATA;
    err    = PSLVERR;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wdata);
    logic [31:0] d;
    logic e, a, b;
    apb_xfer(1'b1, addr, wdata, d, e, a, b);
  endtask

  initial begin
    // ---------------- power-on reset ----------------
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_pready",  {31'h0, PREADY},  32'h0);
    check("rst_prdata",  PRDATA,           32'h0);
    check("rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("rst_irq",     {31'h0, irq},     32'h0);

    // ---------------- handshake ----------------
    apb_xfer(1'b1, 12'h00C, 32'h0000_0005, rd, er, r1, r2);
    check("wr_cmp_t1_pready", {31'h0, r1}, 32'h0);
    check("wr_cmp_t2_pready", {31'h0, r2}, 32'h1);
    check("wr_cmp_pslverr",   {31'h0, er}, 32'h0);
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, r1, r2);
    check("rd_cmp_t1_pready", {31'h0, r1}, 32'h0);
    check("rd_cmp_t2_pready", {31'h0, r2}, 32'h1);
    check("rd_cmp_data",      rd,          32'h0000_0005);
    check("rd_cmp_pslverr",   {31'h0, er}, 32'h0);
    check("pready_drops",     {31'h0, PREADY}, 32'h0);

    // ---------------- address errors ----------------
    apb_xfer(1'b0, 12'h014, 32'h0, rd, er, r1, r2);
    check("rd_0x14_err",  {31'h0, er}, 32'h1);
    check("rd_0x14_data", rd,          32'h0);
    apb_xfer(1'b0, 12'h006, 32'h0, rd, er, r1, r2);
    check("rd_0x06_err",  {31'h0, er}, 32'h1);
    check("rd_0x06_data", rd,          32'h0);
    apb_xfer(1'b1, 12'h00E, 32'h0000_0099, rd, er, r1, r2);
    check("wr_0x0e_err",  {31'h0, er}, 32'h1);
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, r1, r2);
    check("cmp_after_err_wr", rd, 32'h0000_0005);

    // ---------------- prescale / match / auto-reload ----------------
    apb_wr(12'h004, 32'd3);
    apb_wr(12'h00C, 32'd2);
    apb_wr(12'h000, 32'h7);
    // Ticks 4, 8 and 12 cycles after enable; the third one matches.
    repeat (11) @(posedge clk);
    #1 check("presc_irq_before", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("presc_irq_after",  {31'h0, irq}, 32'h1);
    apb_xfer(1'b0, 12'h008, 32'h0, rd, er, r1, r2);
    check("presc_count_reload", rd, 32'h0);
    apb_xfer(1'b0, 12'h010, 32'h0, rd, er, r1, r2);
    check("presc_status", rd, 32'h1);
    apb_xfer(1'b0, 12'h004, 32'h0, rd, er, r1, r2);
    check("presc_readback", rd, 32'd3);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, r1, r2);
    check("ctrl_readback", rd, 32'h7);
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h010, 32'h1);
    apb_xfer(1'b0, 12'h010, 32'h0, rd, er, r1, r2);
    check("status_cleared", rd, 32'h0);

    // ---------------- no reload, 32-bit wrap ----------------
    apb_wr(12'h008, 32'hFFFF_FFFE);
    apb_wr(12'h00C, 32'h0000_0010);
    apb_wr(12'h004, 32'd0);
    apb_wr(12'h000, 32'h1);
    // COUNT after enable edge C+k is k-2 (mod 2^32).
    apb_xfer(1'b0, 12'h008, 32'h0, rd, er, r1, r2);
    check("wrap_count", rd, 32'h0);
    apb_xfer(1'b0, 12'h010, 32'h0, rd, er, r1, r2);
    check("wrap_no_flag", rd, 32'h0);
    repeat (11) @(posedge clk);
    apb_xfer(1'b0, 12'h010, 32'h0, rd, er, r1, r2);
    check("wrap_match_set", rd, 32'h1);
    apb_xfer(1'b0, 12'h008, 32'h0, rd, er, r1, r2);
    check("wrap_count_continues", rd, 32'h0000_0017);
    check("wrap_irq_masked", {31'h0, irq}, 32'h0);
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h010, 32'h1);

    // ---------------- COUNT write collides with tick ----------------
    apb_wr(12'h000, 32'h1);
    apb_wr(12'h008, 32'h0000_0100);
    apb_xfer(1'b0, 12'h008, 32'h0, rd, er, r1, r2);
    check("count_wr_beats_tick", rd, 32'h0000_0102);
    apb_wr(12'h000, 32'h0);

    // ---------------- W1C collides with new match ----------------
    apb_wr(12'h008, 32'h0);
    apb_wr(12'h00C, 32'd4);
    apb_wr(12'h000, 32'h7);
    @(posedge clk);
    apb_wr(12'h010, 32'h1);   // commits on the first match edge
    check("w1c_collide_irq", {31'h0, irq}, 32'h1);
    apb_wr(12'h010, 32'h1);   // one cycle before the next match
    check("w1c_clears_irq", {31'h0, irq}, 32'h0);
    apb_wr(12'h000, 32'h0);
    apb_wr(12'h010, 32'h1);

    // ---------------- EN toggle mid-prescale ----------------
    apb_wr(12'h004, 32'd9);
    apb_wr(12'h008, 32'h0);
    apb_wr(12'h00C, 32'h0);
    apb_wr(12'h000, 32'h5);
    apb_wr(12'h000, 32'h4);   // disabled 4 cycles into a 10-cycle period
    apb_xfer(1'b0, 12'h008, 32'h0, rd, er, r1, r2);
    check("en_off_count_frozen", rd, 32'h0);
    repeat (5) @(posedge clk);
    apb_wr(12'h000, 32'h5);
    repeat (9) @(posedge clk);
    #1 check("en_on_no_early_tick", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("en_on_tick_at_10", {31'h0, irq}, 32'h1);

    // ---------------- reset in the middle of a CMP write ----------------
    apb_wr(12'h00C, 32'h0000_0077);
    check("pre_reset_irq", {31'h0, irq}, 32'h1);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h00C; PWDATA = 32'h0000_1234;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    check("mid_rst_pready",  {31'h0, PREADY},  32'h0);
    check("mid_rst_pslverr", {31'h0, PSLVERR}, 32'h0);
    check("mid_rst_prdata",  PRDATA,           32'h0);
    check("mid_rst_irq",     {31'h0, irq},     32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_rst_pready_idle", {31'h0, PREADY}, 32'h0);
    end
    apb_xfer(1'b0, 12'h00C, 32'h0, rd, er, r1, r2);
    check("mid_rst_cmp", rd, 32'h0);
    check("mid_rst_rd_err", {31'h0, er}, 32'h0);
    apb_xfer(1'b0, 12'h000, 32'h0, rd, er, r1, r2);
    check("mid_rst_ctrl", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
